// File: rtl/cpu_axi_pkg.sv
// Shared AXI read-side constants and refill FSM state type for the CPU
// memory subsystem.
package cpu_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam int LINE_BITS = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_RET
    } refill_state_t;

endpackage

// File: rtl/icache_axi_refill_if.sv
// AXI4 read-only channel bundle (AR + R) between the refill bridge and memory.
interface icache_axi_refill_if #(
    parameter int ID_W = 4
);

    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/icache_axi_refill.sv
// Icache miss refill bridge: one line request becomes one 4-beat AXI INCR
// read burst, returned to the icache as a single-cycle 128-bit line pulse.
module icache_axi_refill
    import cpu_axi_pkg::*;
#(
    parameter int              ID_W       = 4,
    parameter logic [ID_W-1:0] AR_ID      = '0,
    parameter int              LINE_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    resetn,

    input  logic                    rd_req,
    input  logic [31:0]             rd_addr,
    output logic                    rd_rdy,
    output logic                    ret_valid,
    output logic [32*LINE_WORDS-1:0] ret_data,
    output logic                    rd_err,

    icache_axi_refill_if.master     axi
);

    localparam int              CNT_W    = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    refill_state_t                  state;
    logic [27:0]                    addr_q;
    logic [CNT_W-1:0]               cnt;
    logic [LINE_WORDS-1:0][31:0]    line_q;
    logic [32*LINE_WORDS-1:0]       ret_data_q;
    logic                           ret_valid_q;
    logic                           arvalid_q;
    logic                           rready_q;
    logic                           rd_rdy_q;
    logic                           rd_err_q;

    // Line offset bits carry no meaning for a whole-line fetch.
    logic                           unused_offset;
    assign unused_offset = ^rd_addr[3:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            cnt         <= '0;
            line_q      <= '0;
            ret_data_q  <= '0;
            ret_valid_q <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rd_rdy_q    <= 1'b1;
            rd_err_q    <= 1'b0;
        end else begin
            ret_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_req) begin
                        addr_q    <= rd_addr[31:4];
                        cnt       <= '0;
                        rd_rdy_q  <= 1'b0;
                        arvalid_q <= 1'b1;
                        state     <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= ST_R;
                    end
                end
                ST_R: begin
                    if (axi.rvalid) begin
                        line_q[cnt] <= axi.rdata;
                        cnt         <= cnt + 1'b1;
                        if (axi.rresp != AXI_RESP_OKAY)
                            rd_err_q <= 1'b1;
                        if (axi.rlast != (cnt == LAST_BEAT))
                            rd_err_q <= 1'b1;
                        // Beat count, not rlast, terminates the burst.
                        if (cnt == LAST_BEAT) begin
                            rready_q <= 1'b0;
                            state    <= ST_RET;
                        end
                    end
                end
                ST_RET: begin
                    ret_valid_q <= 1'b1;
                    ret_data_q  <= line_q;
                    rd_rdy_q    <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rd_rdy      = rd_rdy_q;
    assign ret_valid   = ret_valid_q;
    assign ret_data    = ret_data_q;
    assign rd_err      = rd_err_q;

    assign axi.arid    = AR_ID;
    assign axi.araddr  = {addr_q, 4'b0000};
    assign axi.arlen   = 8'(LINE_WORDS - 1);
    assign axi.arsize  = AXI_SIZE_4B;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

endmodule
